// File: rtl/dispatch_pkg.sv
// rtl/dispatch_pkg.sv - RV32 opcode constants and register-usage decode for the dispatch stage
package dispatch_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  function automatic logic uses_rs1(input logic [6:0] opcode);
    return opcode inside {OP_JALR, OP_LOAD, OP_IMM, OP_BRANCH, OP_STORE, OP_OP};
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return opcode inside {OP_BRANCH, OP_STORE, OP_OP};
  endfunction

  function automatic logic writes_rd(input logic [6:0] opcode);
    return opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_OP};
  endfunction

endpackage

// File: rtl/dispatch_queue.sv
// rtl/dispatch_queue.sv - circular instruction buffer with count-based full/empty and flush
module dispatch_queue #(
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [INDEX_WIDTH:0]  count
);

  localparam int DEPTH = 1 << INDEX_WIDTH;
  localparam logic [INDEX_WIDTH:0] FULL = {1'b1, {INDEX_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [INDEX_WIDTH-1:0] head;
  logic [INDEX_WIDTH-1:0] tail;
  logic                   push;
  logic                   pop;

  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = mem[head];

  // Pointers wrap by truncation; count alone tells full from empty.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push && !flush && !reset) mem[tail] <= in_data;
  end

endmodule

// File: rtl/dispatch_scoreboard_unit.sv
// rtl/dispatch_scoreboard_unit.sv - in-order dispatch with RAW scoreboard against downstream stages
module dispatch_scoreboard_unit
  import dispatch_pkg::*;
#(
  parameter int CORE           = 0,
  parameter int DATA_WIDTH     = 32,
  parameter int INDEX_WIDTH    = 3,
  parameter int NUM_STAGES     = 4,
  parameter int BYPASS_EN      = 0,
  parameter int LOAD_USE_STAGE = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    report,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_instruction,
  input  logic [7*NUM_STAGES-1:0] stage_opcode,
  input  logic [5*NUM_STAGES-1:0] stage_dest,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_instruction,
  output logic [INDEX_WIDTH:0]    count,
  output logic [31:0]             stall_count
);

  logic                  q_valid;
  logic                  hazard;
  logic [NUM_STAGES-1:0] stage_hz;
  logic [6:0]            head_op;
  logic [4:0]            rs1;
  logic [4:0]            rs2;
  logic                  need_rs1;
  logic                  need_rs2;
  logic                  unused_debug;

  // Debug hooks carry no logic in hardware.
  assign unused_debug = report & (CORE >= 0);

  assign head_op  = out_instruction[6:0];
  assign rs1      = out_instruction[19:15];
  assign rs2      = out_instruction[24:20];
  assign need_rs1 = uses_rs1(head_op);
  assign need_rs2 = uses_rs2(head_op);

  dispatch_queue #(
    .DATA_WIDTH  (DATA_WIDTH),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_instruction),
    .out_valid (q_valid),
    .out_ready (out_ready & ~hazard),
    .out_data  (out_instruction),
    .count     (count)
  );

  // dest != 0 in the writer test is what keeps x0 from ever hazarding.
  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    logic [6:0] op;
    logic [4:0] dst;
    logic       wr;
    logic       match;
    assign op    = stage_opcode[7*i +: 7];
    assign dst   = stage_dest[5*i +: 5];
    assign wr    = writes_rd(op) && (dst != 5'd0);
    assign match = wr && ((need_rs1 && rs1 == dst) || (need_rs2 && rs2 == dst));
    assign stage_hz[i] = (BYPASS_EN == 0) ? match
                       : ((i == LOAD_USE_STAGE) && (op == OP_LOAD) && match);
  end

  assign hazard    = |stage_hz;
  assign out_valid = q_valid & ~hazard;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count <= '0;
    end else if (q_valid && hazard && stall_count != 32'hFFFF_FFFF) begin
      stall_count <= stall_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_dispatch_scoreboard_unit.sv
// tb/tb_dispatch_scoreboard_unit.sv - directed bench for dispatch_scoreboard_unit
module tb_dispatch_scoreboard_unit;

  logic        clock = 1'b0;
  logic        reset, report, flush, in_valid, out_ready;
  logic [31:0] in_instruction;
  logic [27:0] stage_opcode;
  logic [19:0] stage_dest;
  logic        in_ready, out_valid, b_in_ready, b_out_valid;
  logic [31:0] out_instruction, b_out_instruction, stall_count, b_stall_count;
  logic [3:0]  count, b_count;
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  dispatch_scoreboard_unit #(.BYPASS_EN(0)) dut (
    .clock(clock), .reset(reset), .report(report), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instruction(in_instruction),
    .stage_opcode(stage_opcode), .stage_dest(stage_dest),
    .out_valid(out_valid), .out_ready(out_ready), .out_instruction(out_instruction),
    .count(count), .stall_count(stall_count)
  );

  dispatch_scoreboard_unit #(.BYPASS_EN(1), .LOAD_USE_STAGE(1)) dut_byp (
    .clock(clock), .reset(reset), .report(report), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_instruction(in_instruction),
    .stage_opcode(stage_opcode), .stage_dest(stage_dest),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_instruction(b_out_instruction),
    .count(b_count), .stall_count(b_stall_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_stage(input int i, input logic [6:0] op, input logic [4:0] rd);
    stage_opcode[7*i +: 7] = op;
    stage_dest[5*i +: 5]   = rd;
  endtask

  function automatic logic [31:0] addi(input logic [4:0] rd);
    return {12'd0, 5'd0, 3'd0, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
    return {7'd0, b, a, 3'd0, rd, 7'b0110011};
  endfunction

  task automatic push_one(input logic [31:0] w);
    in_valid       = 1'b1;
    in_instruction = w;
    tick();
    in_valid       = 1'b0;
  endtask

  initial begin
    reset = 1'b1; report = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instruction = '0; stage_opcode = '0; stage_dest = '0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_stall", stall_count, 0);
    reset = 1'b0;

    // fill then drain in order
    for (int i = 1; i <= 8; i++) begin
      push_one(addi(5'(i)));
      check("fill_count", count, i);
      check("fill_head", out_instruction, addi(5'd1));
    end
    check("full_in_ready", in_ready, 0);
    check("full_out_valid", out_valid, 1);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("drain_word", out_instruction, addi(5'(i)));
      check("drain_valid", out_valid, 1);
      tick();
    end
    out_ready = 1'b0;
    check("drain_count", count, 0);
    check("drain_out_valid", out_valid, 0);

    // simultaneous push and pop while full
    for (int i = 1; i <= 8; i++) push_one(addi(5'(i)));
    in_valid = 1'b1; in_instruction = addi(5'd9); out_ready = 1'b1;
    #1;
    check("pp_in_ready", in_ready, 0);
    tick();
    check("pp_count7", count, 7);
    check("pp_in_ready2", in_ready, 1);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check("pp_count8", count, 8);
    out_ready = 1'b1;
    for (int i = 2; i <= 9; i++) begin
      check("pp_order", out_instruction, addi(5'(i)));
      tick();
    end
    out_ready = 1'b0;
    check("pp_empty", count, 0);

    // RAW hazard on rs2 from MEM
    set_stage(2, 7'b0110011, 5'd2);
    push_one(add(5'd3, 5'd1, 5'd2));
    check("raw_count", count, 1);
    check("raw_blocked", out_valid, 0);
    check("raw_stall0", stall_count, 0);
    out_ready = 1'b1;
    tick();
    check("raw_stall1", stall_count, 1);
    tick();
    check("raw_stall2", stall_count, 2);
    check("raw_held", count, 1);
    set_stage(2, 7'd0, 5'd0);
    #1;
    check("raw_release", out_valid, 1);
    check("raw_word", out_instruction, add(5'd3, 5'd1, 5'd2));
    tick();
    check("raw_popped", count, 0);
    check("raw_stall_hold", stall_count, 2);
    out_ready = 1'b0;

    // x0 destination and non-writing stage never hazard
    set_stage(1, 7'b0110011, 5'd0);
    set_stage(3, 7'b0100011, 5'd1);
    push_one(add(5'd4, 5'd1, 5'd0));
    check("x0_valid", out_valid, 1);
    tick();
    check("x0_nostall", stall_count, 2);
    set_stage(3, 7'b0000011, 5'd1);
    #1;
    check("wb_load_hz", out_valid, 0);
    stage_opcode = '0; stage_dest = '0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("x0_popped", count, 0);

    // load-use on the forwarding instance
    set_stage(1, 7'b0000011, 5'd5);
    push_one(add(5'd6, 5'd5, 5'd0));
    check("lu_stall", b_out_valid, 0);
    check("lu_stall0", b_stall_count, 0);
    tick();
    check("lu_stall1", b_stall_count, 1);
    check("lu_nobyp_stall", stall_count, 3);
    set_stage(1, 7'b0110011, 5'd5);
    #1;
    check("lu_op_fwd", b_out_valid, 1);
    check("lu_op_nofwd", out_valid, 0);
    set_stage(1, 7'd0, 5'd0);
    set_stage(2, 7'b0000011, 5'd5);
    #1;
    check("lu_mem_fwd", b_out_valid, 1);
    check("lu_mem_nofwd", out_valid, 0);
    stage_opcode = '0; stage_dest = '0;

    // flush overrides push and pop
    for (int i = 10; i <= 13; i++) push_one(addi(5'(i)));
    check("fl_count5", count, 5);
    flush = 1'b1; in_valid = 1'b1; in_instruction = addi(5'd31); out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("fl_count0", count, 0);
    check("fl_out_valid", out_valid, 0);
    check("fl_stall_kept", stall_count, 3);
    push_one(addi(5'd20));
    check("fl_fresh_count", count, 1);
    check("fl_fresh_word", out_instruction, addi(5'd20));

    // reset beats flush and clears stall_count
    reset = 1'b1; flush = 1'b1;
    tick();
    reset = 1'b0; flush = 1'b0;
    check("rf_stall", stall_count, 0);
    check("rf_b_stall", b_stall_count, 0);
    check("rf_count", count, 0);
    check("rf_in_ready", in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dispatch_scoreboard_unit.md
Name: dispatch_scoreboard_unit

Overview:
- Parametrised in-order dispatch stage between fetch and decode.
- Buffers fetched instructions in a circular queue of 2**INDEX_WIDTH entries.
- Scoreboards the destination registers of NUM_STAGES downstream pipeline stages (stage 0 = ID, 1 = EXE, 2 = MEM, 3 = WB).
- Releases the head instruction to decode only when it has no RAW hazard; optional forwarding mode reduces stalls to load-use only.

Parameters:
CORE, 0, core id; debug print only
DATA_WIDTH, 32, instruction width; must be 32 (RV32 field positions)
INDEX_WIDTH, 3, log2 queue depth; depth = 2**INDEX_WIDTH
NUM_STAGES, 4, number of scoreboarded downstream stages
BYPASS_EN, 0, 1 = forwarding present; only load-use hazards stall
LOAD_USE_STAGE, 1, stage index whose LOAD result cannot be forwarded

Ports:
clock  in  1  single clock
reset  in  1  synchronous, active-high
report  in  1  debug: print queue/scoreboard state each cycle; no functional effect
flush  in  1  discard all queued entries
in_valid  in  1  fetch offers in_instruction
in_ready  out  1  queue not full
in_instruction  in  DATA_WIDTH  instruction to enqueue
stage_opcode  in  7*NUM_STAGES  opcode of stage i at bits [7i+6:7i]
stage_dest  in  5*NUM_STAGES  rd of stage i at bits [5i+4:5i]
out_valid  out  1  head is valid and hazard-free
out_ready  in  1  decode accepts
out_instruction  out  DATA_WIDTH  head entry (valid only with out_valid)
count  out  INDEX_WIDTH+1  occupied entries
stall_count  out  32  cycles the head was blocked by a hazard

Behaviour:
- Reset (synchronous, active-high, on clock edge with reset=1): head=0, tail=0, count=0, stall_count=0. Outputs after reset: in_ready=1, out_valid=0. Queue storage is not cleared.
- Push: in_valid & in_ready writes at tail, tail+1 mod depth. in_ready = (count != depth); it does not depend on a same-cycle pop.
- Pop: out_valid & out_ready, head+1 mod depth.
- Push into empty queue: entry visible at out_instruction on the next cycle (1-cycle latency). No combinational fall-through.
- Simultaneous push and pop: count unchanged.
- Pointer wrap: pointers are INDEX_WIDTH bits and wrap naturally; full/empty are distinguished by count.
- Source decode from head (RV32): rs1 = [19:15], rs2 = [24:20].
  - Uses rs1: JALR 1100111, LOAD 0000011, OP-IMM 0010011, BRANCH 1100011, STORE 0100011, OP 0110011.
  - Uses rs2: BRANCH, STORE, OP.
  - LUI, AUIPC, JAL and unknown opcodes use no sources.
- Stage i writes a register iff its opcode is in {LUI 0110111, AUIPC 0010111, JAL, JALR, LOAD, OP-IMM, OP} and stage_dest[i] != 0.
- Hazard:
  - BYPASS_EN=0: any used source equals the dest of any writing stage.
  - BYPASS_EN=1: only a match against stage LOAD_USE_STAGE whose opcode is LOAD.
  - x0 never hazards.
- out_valid = (count != 0) & ~hazard. This is combinational from registered queue state and the current stage inputs.
- stall_count increments when count != 0 & hazard. It saturates at 2^32-1.
- flush: next cycle head=tail=0, count=0.
  - Overrides a same-cycle push (dropped) and pop (treated as not accepted).
  - stall_count is kept.
- reset overrides flush.
- Stage inputs are sampled each cycle. The issued instruction appears in stage 0 on the next cycle via the pipeline; this block does not self-track issued instructions.
- report=1: $display of CORE, head, tail, count, hazard. Simulation only.

Decomposition:
- Shared package dispatch_pkg:
  - opcode localparams (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_OP);
  - functions uses_rs1(opcode), uses_rs2(opcode), writes_rd(opcode).
- One sub-module: dispatch_queue, the parametrised circular buffer with pointers, count, flush, valid/ready on both sides.
- The top level holds the hazard comparators (generate loop over NUM_STAGES) and stall_count.

Test Plan:
- Fill/drain: reset, push 8 × ADDI x1..x8, stages idle, out_ready=0 → in_ready=0 after 8th, count=8. Then out_ready=1 → 8 pops in order, count=0, tail/head wrapped to 0.
- RAW stall (BYPASS_EN=0): head ADD x3,x1,x2 with stage 2 = OP rd=x2 → out_valid=0, stall_count +1 per cycle. Stage 2 clears → out_valid=1.
- x0 and non-writers: stage 1 = OP rd=x0, stage 3 = STORE with dest field=x1, head uses x1 → out_valid=1, no stall.
- Load-use (BYPASS_EN=1): stage 1 = LOAD rd=x5, head ADD x6,x5,x0 → stall. Stage 1 = OP rd=x5 → no stall. Stage 2 = LOAD rd=x5 → no stall.
- Simultaneous push/pop at full (count=8): in_valid=1, out_ready=1 → push rejected (in_ready=0), pop occurs, count=7. Next cycle push accepted, count=8.
- Flush and reset mid-operation:
  - count=5, flush with in_valid=1 and out_ready=1 → count=0 next cycle, pushed word absent, stall_count unchanged.
  - reset=1 with flush=1 → stall_count=0, count=0.
